// File: rtl/pci_tl_defs.sv
// Shared transaction-layer definitions: control FSM encoding and default FIFO geometry.
package pci_tl_defs;

  typedef enum logic {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } tl_state_e;

  localparam int unsigned DefDataWidth = 6;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefNumVc     = 2;

endpackage

// File: rtl/vc_fifo_channel.sv
// One virtual-channel queue: storage, pointers, occupancy count, flags and error.
// Macro VC_FIFO_STICKY_ERR_EN makes the error output latch until clear/reset.
module vc_fifo_channel
  import pci_tl_defs::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] umbral_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  do_wr, do_rd, err_ev;

  always_comb begin
    full         = (cnt_q == DepthCnt);
    empty        = (cnt_q == '0);
    almost_full  = (cnt_q >= (DepthCnt - {1'b0, umbral_q}));
    almost_empty = (cnt_q <= {1'b0, umbral_q});
  end

  // A read on a full queue frees the slot the concurrent write lands in.
  // An empty queue never bypasses: the read underflows, the write is still stored.
  always_comb begin
    do_rd  = rd_en & ~clear & ~empty;
    do_wr  = wr_en & ~clear & (~full | do_rd);
    err_ev = ~clear & ((wr_en & full & ~do_rd) | (rd_en & empty));
    cnt_d  = cnt_q;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else if (clear) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q     <= cnt_d;
      data_out  <= do_rd ? mem[rd_ptr_q] : '0;
      valid_out <= do_rd;
`ifdef VC_FIFO_STICKY_ERR_EN
      error     <= error | err_ev;
`else
      error     <= err_ev;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// NUM_VC virtual-channel FIFO bank: control FSM, threshold capture and write steering.
// Macro VC_FIFO_STICKY_ERR_EN (in vc_fifo_channel) selects sticky vs pulsed error.
module vc_fifo_bank
  import pci_tl_defs::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_VC     = DefNumVc,
  parameter int unsigned VC_SEL_W   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic                         wr_enable,
  input  logic [VC_SEL_W-1:0]          wr_vc,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [NUM_VC-1:0]            rd_enable,
  input  logic [NUM_VC*ADDR_WIDTH-1:0] umbral,
  output logic [NUM_VC*DATA_WIDTH-1:0] data_out,
  output logic [NUM_VC-1:0]            valid_out,
  output logic [NUM_VC-1:0]            full,
  output logic [NUM_VC-1:0]            empty,
  output logic [NUM_VC-1:0]            almost_full,
  output logic [NUM_VC-1:0]            almost_empty,
  output logic [NUM_VC-1:0]            error
);

  tl_state_e                    state_q, state_d;
  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_q;
  logic                         clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   if (init)  state_d = ST_ACTIVE;
      ST_ACTIVE: if (!init) state_d = ST_INIT;
      default:   state_d = ST_INIT;
    endcase
  end

  // Dropping init clears on the same edge, not one cycle later.
  always_comb begin
    clear = (state_q != ST_ACTIVE) | ~init;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 umbral_q <= '0;
    else if (state_q == ST_INIT) umbral_q <= umbral;
  end

  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    logic wr_sel;
    // Out-of-range wr_vc matches no lane, so the word is silently dropped.
    assign wr_sel = wr_enable & (wr_vc == VC_SEL_W'(k));

    vc_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .wr_en        (wr_sel),
      .rd_en        (rd_enable[k]),
      .data_in      (data_in),
      .umbral_q     (umbral_q[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .data_out     (data_out[k*DATA_WIDTH +: DATA_WIDTH]),
      .valid_out    (valid_out[k]),
      .full         (full[k]),
      .empty        (empty[k]),
      .almost_full  (almost_full[k]),
      .almost_empty (almost_empty[k]),
      .error        (error[k])
    );
  end

endmodule
